// File: rtl/register_file_snapshot_if.sv
// Bus bundle for register_file_snapshot: read/write ports plus checkpoint control.
// The master side drives the requests and the slave side (the register file) answers them.
interface register_file_snapshot_if #(
  parameter int DW     = 8,
  parameter int NREGS  = 4,
  parameter int NUM_RD = 1,
  parameter int NUM_WR = 1
) ();
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_WR-1:0]    wr_call;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic                 snap_call;
  logic                 restore_call;
  logic                 snap_valid;
  logic                 restore_err;

  modport master (
    output rd_addr, wr_call, wr_addr, wr_data, snap_call, restore_call,
    input  rd_data, snap_valid, restore_err
  );

  modport slave (
    input  rd_addr, wr_call, wr_addr, wr_data, snap_call, restore_call,
    output rd_data, snap_valid, restore_err
  );
endinterface

// File: rtl/register_file_snapshot.sv
// Multi-port register file with optional read bypass and a single-level snapshot/restore shadow.
// Defining REGFILE_DUMP_EN adds the dump_data and shadow_data observation outputs.
module register_file_snapshot #(
  parameter int             DW        = 8,
  parameter int             NREGS     = 4,
  parameter int             NUM_RD    = 1,
  parameter int             NUM_WR    = 1,
  parameter int             BYPASS    = 1,
  parameter logic [DW-1:0]  RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  register_file_snapshot_if.slave  bus
`ifdef REGFILE_DUMP_EN
  ,
  output logic [NREGS*DW-1:0]      dump_data,
  output logic [NREGS*DW-1:0]      shadow_data
`endif
);
  localparam int AW = $clog2(NREGS);

  logic [DW-1:0] regs     [NREGS];
  logic [DW-1:0] shadow   [NREGS];
  logic [DW-1:0] wr_chain [NREGS];
  logic [DW-1:0] next_reg [NREGS];
  logic          snap_valid;
  logic          restore_err;
  logic          do_restore;

  assign do_restore = bus.restore_call && snap_valid;

  // Later write ports overwrite earlier ones; addresses >= NREGS match no register.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_chain[r] = regs[r];
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_call[w] && (bus.wr_addr[w*AW +: AW] == AW'(r))) begin
          wr_chain[r] = bus.wr_data[w*DW +: DW];
        end
      end
      next_reg[r] = do_restore ? shadow[r] : wr_chain[r];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r]   <= RESET_VAL;
        shadow[r] <= RESET_VAL;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= next_reg[r];
        if (bus.snap_call && !do_restore) begin
          shadow[r] <= wr_chain[r];
        end
      end
    end
  end

  // A snapshot requested alongside an effective restore re-arms the checkpoint.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_valid  <= 1'b0;
      restore_err <= 1'b0;
    end else begin
      restore_err <= bus.restore_call && !snap_valid;
      if (do_restore) begin
        snap_valid <= bus.snap_call;
      end else if (bus.snap_call) begin
        snap_valid <= 1'b1;
      end
    end
  end

  assign bus.snap_valid  = snap_valid;
  assign bus.restore_err = restore_err;

  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (bus.rd_addr[p*AW +: AW] == AW'(r)) begin
          if (reset) begin
            bus.rd_data[p*DW +: DW] = RESET_VAL;
          end else if (BYPASS != 0) begin
            bus.rd_data[p*DW +: DW] = next_reg[r];
          end else begin
            bus.rd_data[p*DW +: DW] = regs[r];
          end
        end
      end
    end
  end

`ifdef REGFILE_DUMP_EN
  always_comb begin
    dump_data   = '0;
    shadow_data = '0;
    for (int r = 0; r < NREGS; r++) begin
      dump_data[r*DW +: DW]   = regs[r];
      shadow_data[r*DW +: DW] = shadow[r];
    end
  end
`endif
endmodule

// File: tb/tb_register_file_snapshot.sv
// Directed bench for register_file_snapshot: bypassed 2R/2W file, a non-bypassed copy,
// and a 3-entry copy for out-of-range addressing.
module tb_register_file_snapshot;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  register_file_snapshot_if #(.DW(8), .NREGS(4), .NUM_RD(2), .NUM_WR(2)) ifa ();
  register_file_snapshot_if #(.DW(8), .NREGS(4), .NUM_RD(2), .NUM_WR(2)) ifb ();
  register_file_snapshot_if #(.DW(8), .NREGS(3), .NUM_RD(1), .NUM_WR(1)) ifc ();

`ifdef REGFILE_DUMP_EN
  logic [31:0] dump_a, shadow_a, dump_b, shadow_b;
  logic [23:0] dump_c, shadow_c;
`endif

  register_file_snapshot #(.DW(8), .NREGS(4), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
`ifdef REGFILE_DUMP_EN
    , .dump_data(dump_a), .shadow_data(shadow_a)
`endif
  );

  register_file_snapshot #(.DW(8), .NREGS(4), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
`ifdef REGFILE_DUMP_EN
    , .dump_data(dump_b), .shadow_data(shadow_b)
`endif
  );

  register_file_snapshot #(.DW(8), .NREGS(3), .NUM_RD(1), .NUM_WR(1), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc.slave)
`ifdef REGFILE_DUMP_EN
    , .dump_data(dump_c), .shadow_data(shadow_c)
`endif
  );

  task automatic idle();
    ifa.rd_addr = '0; ifa.wr_call = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.snap_call = 1'b0; ifa.restore_call = 1'b0;
    ifb.rd_addr = '0; ifb.wr_call = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.snap_call = 1'b0; ifb.restore_call = 1'b0;
    ifc.rd_addr = '0; ifc.wr_call = '0; ifc.wr_addr = '0; ifc.wr_data = '0;
    ifc.snap_call = 1'b0; ifc.restore_call = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #1;
    checks++; if (ifa.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd act=%h exp=%h", ifa.rd_data, 16'h0000); end
    checks++; if (ifa.snap_valid !== 1'b0) begin errors++; $display("FAIL reset_snap_valid act=%b exp=0", ifa.snap_valid); end
    checks++; if (ifa.restore_err !== 1'b0) begin errors++; $display("FAIL reset_restore_err act=%b exp=0", ifa.restore_err); end
    checks++; if (ifb.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_nobypass act=%h exp=%h", ifb.rd_data, 16'h0000); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_collision();
    @(negedge clk);
    ifa.wr_call = 2'b11;
    ifa.wr_addr = {2'd1, 2'd1};
    ifa.wr_data = {8'h22, 8'h11};
    ifa.rd_addr = {2'd0, 2'd1};
    #1;
    checks++; if (ifa.rd_data[7:0] !== 8'h22) begin errors++; $display("FAIL collision_bypass act=%h exp=%h", ifa.rd_data[7:0], 8'h22); end
    checks++; if (ifa.rd_data[15:8] !== 8'h00) begin errors++; $display("FAIL collision_other_reg act=%h exp=%h", ifa.rd_data[15:8], 8'h00); end
    @(negedge clk);
    idle();
    ifa.rd_addr = {2'd0, 2'd1};
    #1;
    checks++; if (ifa.rd_data[7:0] !== 8'h22) begin errors++; $display("FAIL collision_held act=%h exp=%h", ifa.rd_data[7:0], 8'h22); end
  endtask

  task automatic test_snapshot_restore();
    @(negedge clk);
    idle();
    ifa.wr_call = 2'b01; ifa.wr_addr = {2'd0, 2'd2}; ifa.wr_data = {8'h00, 8'h5A};
    ifa.snap_call = 1'b1;
    ifa.rd_addr = {2'd3, 2'd2};
    @(negedge clk);
    checks++; if (ifa.snap_valid !== 1'b1) begin errors++; $display("FAIL snap_valid_set act=%b exp=1", ifa.snap_valid); end
    ifa.snap_call = 1'b0;
    ifa.wr_data = {8'h00, 8'h7F};
    #1;
    checks++; if (ifa.rd_data[7:0] !== 8'h7F) begin errors++; $display("FAIL overwrite_bypass act=%h exp=%h", ifa.rd_data[7:0], 8'h7F); end
    @(negedge clk);
    ifa.restore_call = 1'b1;
    ifa.wr_call = 2'b10; ifa.wr_addr = {2'd3, 2'd0}; ifa.wr_data = {8'h66, 8'h00};
    #1;
    checks++; if (ifa.rd_data[7:0] !== 8'h5A) begin errors++; $display("FAIL restore_bypass act=%h exp=%h", ifa.rd_data[7:0], 8'h5A); end
    checks++; if (ifa.rd_data[15:8] !== 8'h00) begin errors++; $display("FAIL restore_drops_write act=%h exp=%h", ifa.rd_data[15:8], 8'h00); end
    @(negedge clk);
    idle();
    ifa.rd_addr = {2'd3, 2'd2};
    #1;
    checks++; if (ifa.rd_data !== 16'h005A) begin errors++; $display("FAIL restore_after act=%h exp=%h", ifa.rd_data, 16'h005A); end
    checks++; if (ifa.snap_valid !== 1'b0) begin errors++; $display("FAIL snap_consumed act=%b exp=0", ifa.snap_valid); end
  endtask

  task automatic test_restore_err();
    @(negedge clk);
    idle();
    ifa.restore_call = 1'b1;
    ifa.wr_call = 2'b01; ifa.wr_addr = {2'd0, 2'd3}; ifa.wr_data = {8'h00, 8'h33};
    ifa.rd_addr = {2'd3, 2'd0};
    #1;
    checks++; if (ifa.rd_data[15:8] !== 8'h33) begin errors++; $display("FAIL err_write_bypass act=%h exp=%h", ifa.rd_data[15:8], 8'h33); end
    checks++; if (ifa.restore_err !== 1'b0) begin errors++; $display("FAIL err_not_early act=%b exp=0", ifa.restore_err); end
    @(negedge clk);
    idle();
    ifa.rd_addr = {2'd3, 2'd0};
    checks++; if (ifa.restore_err !== 1'b1) begin errors++; $display("FAIL err_pulse act=%b exp=1", ifa.restore_err); end
    @(negedge clk);
    checks++; if (ifa.restore_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle act=%b exp=0", ifa.restore_err); end
    checks++; if (ifa.rd_data[15:8] !== 8'h33) begin errors++; $display("FAIL err_write_kept act=%h exp=%h", ifa.rd_data[15:8], 8'h33); end
  endtask

  task automatic test_snap_restore_same();
    @(negedge clk);
    idle();
    ifa.wr_call = 2'b01; ifa.wr_addr = '0; ifa.wr_data = {8'h00, 8'h44};
    ifa.snap_call = 1'b1;
    @(negedge clk);
    ifa.snap_call = 1'b0;
    ifa.wr_data = {8'h00, 8'h99};
    @(negedge clk);
    ifa.wr_call = 2'b00;
    checks++; if (ifa.rd_data[7:0] !== 8'h99) begin errors++; $display("FAIL pre_regs_r0 act=%h exp=%h", ifa.rd_data[7:0], 8'h99); end
    ifa.snap_call = 1'b1;
    ifa.restore_call = 1'b1;
    #1;
    checks++; if (ifa.rd_data[7:0] !== 8'h44) begin errors++; $display("FAIL same_cycle_bypass act=%h exp=%h", ifa.rd_data[7:0], 8'h44); end
    @(negedge clk);
    ifa.snap_call = 1'b0;
    checks++; if (ifa.snap_valid !== 1'b1) begin errors++; $display("FAIL snap_rearmed act=%b exp=1", ifa.snap_valid); end
    ifa.wr_call = 2'b01; ifa.wr_data = {8'h00, 8'h55};
    #1;
    checks++; if (ifa.rd_data[7:0] !== 8'h44) begin errors++; $display("FAIL second_restore_bypass act=%h exp=%h", ifa.rd_data[7:0], 8'h44); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (ifa.rd_data[7:0] !== 8'h44) begin errors++; $display("FAIL second_restore_after act=%h exp=%h", ifa.rd_data[7:0], 8'h44); end
    checks++; if (ifa.snap_valid !== 1'b0) begin errors++; $display("FAIL second_restore_consumes act=%b exp=0", ifa.snap_valid); end
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    idle();
    ifb.wr_call = 2'b01; ifb.wr_addr = {2'd0, 2'd1}; ifb.wr_data = {8'h00, 8'hAB};
    ifb.rd_addr = {2'd0, 2'd1};
    #1;
    checks++; if (ifb.rd_data[7:0] !== 8'h00) begin errors++; $display("FAIL nobypass_old act=%h exp=%h", ifb.rd_data[7:0], 8'h00); end
    @(negedge clk);
    idle();
    ifb.rd_addr = {2'd0, 2'd1};
    #1;
    checks++; if (ifb.rd_data[7:0] !== 8'hAB) begin errors++; $display("FAIL nobypass_new act=%h exp=%h", ifb.rd_data[7:0], 8'hAB); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    idle();
    ifc.wr_call = 1'b1; ifc.wr_addr = 2'd3; ifc.wr_data = 8'hFF;
    ifc.rd_addr = 2'd3;
    #1;
    checks++; if (ifc.rd_data !== 8'h00) begin errors++; $display("FAIL oor_read act=%h exp=%h", ifc.rd_data, 8'h00); end
    @(negedge clk);
    ifc.wr_addr = 2'd2; ifc.wr_data = 8'h5C;
    @(negedge clk);
    idle();
    ifc.rd_addr = 2'd2;
    #1;
    checks++; if (ifc.rd_data !== 8'h5C) begin errors++; $display("FAIL oor_valid_write act=%h exp=%h", ifc.rd_data, 8'h5C); end
    for (int a = 0; a < 2; a++) begin
      ifc.rd_addr = 2'(a);
      #1;
      checks++; if (ifc.rd_data !== 8'h00) begin errors++; $display("FAIL oor_no_alias r%0d act=%h exp=%h", a, ifc.rd_data, 8'h00); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle();
    ifa.snap_call = 1'b1;
    @(negedge clk);
    idle();
    ifa.rd_addr = {2'd2, 2'd0};
    ifb.rd_addr = {2'd0, 2'd1};
    #1;
    checks++; if (ifa.rd_data !== 16'h5A44) begin errors++; $display("FAIL pre_reset_regs act=%h exp=%h", ifa.rd_data, 16'h5A44); end
    checks++; if (ifa.snap_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_snap act=%b exp=1", ifa.snap_valid); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (ifa.rd_data !== 16'h0000) begin errors++; $display("FAIL async_reset_rd act=%h exp=%h", ifa.rd_data, 16'h0000); end
    checks++; if (ifa.snap_valid !== 1'b0) begin errors++; $display("FAIL async_reset_snap act=%b exp=0", ifa.snap_valid); end
    checks++; if (ifb.rd_data[7:0] !== 8'h00) begin errors++; $display("FAIL async_reset_nobypass act=%h exp=%h", ifb.rd_data[7:0], 8'h00); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ifa.rd_data !== 16'h0000) begin errors++; $display("FAIL post_reset_rd act=%h exp=%h", ifa.rd_data, 16'h0000); end
  endtask

  initial begin
    test_reset();
    test_write_collision();
    test_snapshot_restore();
    test_restore_err();
    test_snap_restore_same();
    test_no_bypass();
    test_out_of_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
